popcount_pipe: RTL and testbench

//   Parametrised, pipelined population count. Counts the set bits of a

---
 rtl/popcount_pipe.sv | 152 +++++++++++++++
 tb/tb_popcount_pipe.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/popcount_pipe.sv
// popcount_pipe: pipelined population count over a balanced adder tree with a
// valid/ready stream on both sides. Define POPCNT_ACC_EN to build the group accumulator.
module popcount_pipe #(
  parameter int WIDTH  = 128,
  parameter int STAGES = 2,
  parameter int ACC_W  = 16,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  input  logic             last_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic [ACC_W-1:0] acc_o,
  output logic             last_o,
  output logic             sat_o
);

  // Handshake: a beat moves on any port in a cycle where valid and ready are both
  // high. Once valid_o is up, the beat and its sidebands hold until ready_i takes it.
  localparam int L  = $clog2(WIDTH);
  localparam int N  = 1 << L;
  localparam int SW = L + 1;
  localparam int SD = (STAGES > 0) ? STAGES : 1;

  // Stage k registers the tree after level ceil((k+1)*L/STAGES). When the levels
  // do not divide evenly, the earlier stages take the extra levels.
  function automatic int stage_of(int lv);
    int s;
    s = -1;
    for (int k = 0; k < STAGES; k++)
      if (((k + 1) * L + STAGES - 1) / STAGES == lv) s = k;
    return s;
  endfunction

  logic [SD-1:0] en;
  logic [N-1:0]  leaves;

  assign leaves = N'(data_i);

  if (STAGES == 0) begin : g_comb
    logic unused_en;
    assign en        = '0;
    assign unused_en = ^en;
    assign valid_o   = valid_i;
    assign ready_o   = ready_i;
  end else begin : g_pipe
    logic [SD-1:0] vq;
    logic [SD-1:0] free;
    logic [SD-1:0] up;

    // free[k]: stage k is empty or its beat leaves this cycle, so it can load.
    always_comb begin
      logic down;
      down = ready_i;
      free = '0;
      for (int k = SD - 1; k >= 0; k--) begin
        free[k] = !vq[k] || down;
        down    = free[k];
      end
    end

    assign up      = (vq << 1) | SD'(valid_i);
    assign en      = up & free;
    assign valid_o = vq[SD-1];
    assign ready_o = free[0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) vq <= '0;
      else         vq <= (up & free) | (vq & ~free);
    end
  end

  for (genvar l = 0; l <= L; l++) begin : lvl
    localparam int NL = N >> l;
    localparam int SK = stage_of(l);
    logic [SW-1:0] o [NL];
    if (l == 0) begin : g_leaf
      for (genvar n = 0; n < NL; n++) begin : g_bit
        assign o[n] = SW'(leaves[n]);
      end
    end else begin : g_add
      logic [SW-1:0] s [NL];
      for (genvar n = 0; n < NL; n++) begin : g_sum
        assign s[n] = lvl[l-1].o[2*n] + lvl[l-1].o[2*n+1];
      end
      if (SK >= 0) begin : g_reg
        always_ff @(posedge clk_i or negedge rst_ni) begin
          if (!rst_ni) begin
            for (int n = 0; n < NL; n++) o[n] <= '0;
          end else if (en[SK]) begin
            for (int n = 0; n < NL; n++) o[n] <= s[n];
          end
        end
      end else begin : g_wire
        assign o = s;
      end
    end
  end

  assign cnt_o = CNT_W'(lvl[L].o[0]);

`ifdef POPCNT_ACC_EN
  localparam int AW1 = ACC_W + 1;
  logic             out_last;
  logic [ACC_W-1:0] acc_q;
  logic             sat_q;
  logic [ACC_W:0]   acc_sum;
  logic             clamp;

  if (STAGES == 0) begin : g_last0
    assign out_last = last_i;
  end else begin : g_last
    logic [SD-1:0] lq;
    logic [SD-1:0] lin;
    assign lin      = (lq << 1) | SD'(last_i);
    assign out_last = lq[SD-1];
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) lq <= '0;
      else         lq <= (lin & en) | (lq & ~en);
    end
  end

  // The sum is shown with the beat itself, so a one-beat group reports its own count.
  assign acc_sum = {1'b0, acc_q} + AW1'(cnt_o);
  assign clamp   = acc_sum[ACC_W];
  assign acc_o   = clamp ? '1 : acc_sum[ACC_W-1:0];
  assign sat_o   = sat_q || clamp;
  assign last_o  = out_last;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
      sat_q <= 1'b0;
    end else if (valid_o && ready_i) begin
      acc_q <= out_last ? '0 : acc_o;
      sat_q <= !out_last && sat_o;
    end
  end
`else
  logic unused_last;
  assign unused_last = last_i;
  assign acc_o       = '0;
  assign last_o      = 1'b0;
  assign sat_o       = 1'b0;
`endif

endmodule

// File: tb/tb_popcount_pipe.sv
// Bench for popcount_pipe: scoreboard queue filled by the drivers, drained by a monitor;
// extra instances cover the STAGES sweep and, with POPCNT_ACC_EN, an 8-bit accumulator.
module tb_popcount_pipe;
  localparam int W  = 128;
  localparam int S  = 2;
  localparam int CW = 8;
  localparam int AW = 16;
  localparam int EW = CW + AW + 2;
  localparam longint AMAX = (longint'(1) << AW) - 1;
`ifdef POPCNT_ACC_EN
  localparam bit ACC_ON = 1'b1;
`else
  localparam bit ACC_ON = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic          valid_i = 1'b0;
  logic          ready_i = 1'b1;
  logic          last_i  = 1'b0;
  logic [W-1:0]  data_i  = '0;
  logic          ready_o, valid_o, last_o, sat_o;
  logic [CW-1:0] cnt_o;
  logic [AW-1:0] acc_o;

  popcount_pipe #(.WIDTH(W), .STAGES(S), .ACC_W(AW)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
    .data_i(data_i), .last_i(last_i), .valid_o(valid_o), .ready_i(ready_i),
    .cnt_o(cnt_o), .acc_o(acc_o), .last_o(last_o), .sat_o(sat_o)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int            hs_q[$];
  longint        grp_sum = 0;

  function automatic int ones(input logic [W-1:0] d);
    int c;
    c = 0;
    for (int i = 0; i < W; i++) c += int'(d[i]);
    return c;
  endfunction

  task automatic expect_beat(input logic [W-1:0] d, input logic l);
    int c;
    logic [AW-1:0] a;
    logic sat, le;
    c = ones(d);
    if (ACC_ON) begin
      grp_sum += c;
      sat = grp_sum > AMAX;
      a   = sat ? AW'(AMAX) : AW'(grp_sum);
      le  = l;
      if (l) grp_sum = 0;
    end else begin
      a = '0; sat = 1'b0; le = 1'b0;
    end
    exp_q.push_back({CW'(c), a, le, sat});
  endtask

  logic [EW-1:0] mon_e;
  always @(negedge clk) begin
    if (rst_ni && valid_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL extra_beat: got cnt %0d expected no beat (cycle %0d)", cnt_o, cyc);
      end else begin
        mon_e = exp_q[0];
        check("cnt",  cnt_o,  mon_e[EW-1 -: CW]);
        check("acc",  acc_o,  mon_e[AW+1 -: AW]);
        check("last", last_o, mon_e[1]);
        check("sat",  sat_o,  mon_e[0]);
        if (ready_i) begin
          void'(exp_q.pop_front());
          hs_q.push_back(cyc + 1);
        end
      end
    end
  end

  // ---------------- drivers ----------------
  int stalls = 0;

  task automatic send(input logic [W-1:0] d, input logic l, output int c_in);
    int  n;
    logic took;
    n = 0;
    took = 1'b0;
    valid_i = 1'b1;
    data_i  = d;
    last_i  = l;
    expect_beat(d, l);
    while (!took && n < 200) begin
      @(negedge clk);
      took = ready_o;
      if (!took) stalls++;
      @(posedge clk);
      #1;
      n++;
    end
    c_in    = cyc;
    valid_i = 1'b0;
    last_i  = 1'b0;
    if (!took) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got no ready_o expected accept within 200 cycles");
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    check("drain_left", exp_q.size(), 0);
    exp_q.delete();
    repeat (6) @(posedge clk);
    #1;
  endtask

  // ---------------- STAGES sweep instances (case 2) ----------------
  logic          sw_v = 1'b0;
  int            sw_t0 = 0;
  logic [CW-1:0] sw_exp [3] = '{8'd64, 8'd1, 8'd5};

  for (genvar i = 0; i < 3; i++) begin : g_sw
    localparam int SS = (i == 0) ? 0 : (i == 1) ? 1 : 7;
    logic          vo, ro, lo, so;
    logic [CW-1:0] co;
    logic [AW-1:0] ao;
    int            idx = 0;
    int            first = 0;
    popcount_pipe #(.WIDTH(W), .STAGES(SS), .ACC_W(AW)) u (
      .clk_i(clk), .rst_ni(rst_ni), .valid_i(sw_v), .ready_o(ro),
      .data_i(data_i), .last_i(1'b1), .valid_o(vo), .ready_i(1'b1),
      .cnt_o(co), .acc_o(ao), .last_o(lo), .sat_o(so)
    );
    always @(negedge clk) begin
      if (rst_ni && vo) begin
        if (idx >= 3) begin
          checks++;
          failures++;
          $display("FAIL sweep%0d_extra: got beat %0d expected 3 beats", SS, idx + 1);
        end else begin
          check($sformatf("sweep%0d_cnt", SS), co, sw_exp[idx]);
          check($sformatf("sweep%0d_acc", SS), ao, ACC_ON ? longint'(sw_exp[idx]) : 0);
          check($sformatf("sweep%0d_last", SS), lo, ACC_ON ? 1 : 0);
          check($sformatf("sweep%0d_sat", SS), so, 0);
          check($sformatf("sweep%0d_ready", SS), ro, 1);
          if (idx == 0) begin
            first = cyc + 1;
            check($sformatf("sweep%0d_latency", SS), cyc + 1 - sw_t0, SS);
          end else begin
            check($sformatf("sweep%0d_gap", SS), cyc + 1 - first, idx);
          end
        end
        idx++;
      end
    end
  end

`ifdef POPCNT_ACC_EN
  // ---------------- 8-bit accumulator instance (case 6) ----------------
  logic         v6 = 1'b0;
  logic         vo6, ro6, lo6, so6;
  logic [CW-1:0] co6;
  logic [7:0]   ao6;
  int           idx6 = 0;
  int           a6_exp [4] = '{128, 255, 255, 128};
  int           s6_exp [4] = '{0, 1, 1, 0};
  int           l6_exp [4] = '{0, 0, 1, 0};

  popcount_pipe #(.WIDTH(W), .STAGES(S), .ACC_W(8)) d6 (
    .clk_i(clk), .rst_ni(rst_ni), .valid_i(v6), .ready_o(ro6),
    .data_i(data_i), .last_i(last_i), .valid_o(vo6), .ready_i(1'b1),
    .cnt_o(co6), .acc_o(ao6), .last_o(lo6), .sat_o(so6)
  );

  always @(negedge clk) begin
    if (rst_ni && vo6) begin
      if (idx6 >= 4) begin
        checks++;
        failures++;
        $display("FAIL acc8_extra: got beat %0d expected 4 beats", idx6 + 1);
      end else begin
        check("acc8_cnt",  co6, 128);
        check("acc8_acc",  ao6, a6_exp[idx6]);
        check("acc8_sat",  so6, s6_exp[idx6]);
        check("acc8_last", lo6, l6_exp[idx6]);
        check("acc8_ready", ro6, 1);
      end
      idx6++;
    end
  end
`endif

  // ---------------- random backpressure ----------------
  logic rnd_rdy = 1'b0;
  always @(posedge clk) begin
    if (rnd_rdy) begin
      #1;
      ready_i = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected end before 400000");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  int c0, c1, c2;
  logic [W-1:0] pat;

  initial begin
    #2;
    check("rst_valid_o", valid_o, 0);
    check("rst_cnt_o", cnt_o, 0);
    check("rst_acc_o", acc_o, 0);
    check("rst_last_o", last_o, 0);
    check("rst_sat_o", sat_o, 0);
    check("rst_ready_o", ready_o, 1);
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // case 1: all ones then all zeros, latency 2
    hs_q.delete();
    send('1, 1'b1, c0);
    send('0, 1'b1, c1);
    drain();
    check("t1_beats", hs_q.size(), 2);
    if (hs_q.size() == 2) begin
      check("t1_latency", hs_q[0] - c0, S);
      check("t1_latency0", hs_q[1] - c1, S);
    end

    // case 2: back-to-back beats, also fed to the STAGES sweep instances
    hs_q.delete();
    sw_t0 = cyc + 1;
    sw_v  = 1'b1;
    pat = {64{2'b01}};
    send(pat, 1'b1, c0);
    pat = 128'h1;
    send(pat, 1'b1, c1);
    pat = {1'b1, 123'h0, 4'hf};
    send(pat, 1'b1, c2);
    sw_v = 1'b0;
    drain();
    check("t2_beats", hs_q.size(), 3);
    if (hs_q.size() == 3) begin
      check("t2_latency", hs_q[0] - c0, S);
      check("t2_consec1", hs_q[1] - hs_q[0], 1);
      check("t2_consec2", hs_q[2] - hs_q[0], 2);
    end
    check("sweep0_beats", g_sw[0].idx, 3);
    check("sweep1_beats", g_sw[1].idx, 3);
    check("sweep7_beats", g_sw[2].idx, 3);

    // case 3: 8 random beats with ready_i low for 3 cycles mid-stream
    stalls = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          pat = {$urandom, $urandom, $urandom, $urandom};
          send(pat, 1'(i == 7), c0);
        end
      end
      begin
        repeat (4) @(posedge clk);
        #1 ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 ready_i = 1'b1;
      end
    join
    drain();
    check("t3_ready_drop", stalls > 0, 1);

    // case 4: reset with two beats in flight
    send('1, 1'b0, c0);
    pat = 128'h3;
    send(pat, 1'b0, c1);
    rst_ni = 1'b0;
    #1;
    check("t4_valid_in_reset", valid_o, 0);
    check("t4_cnt_in_reset", cnt_o, 0);
    exp_q.delete();
    grp_sum = 0;
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
    hs_q.delete();
    send('1, 1'b1, c0);
    drain();
    check("t4_beats", hs_q.size(), 1);
    if (hs_q.size() == 1) check("t4_latency", hs_q[0] - c0, S);

    // case 5: group 128 + 1 + 0 with last on beat 3, then a 3-ones beat
    send('1, 1'b0, c0);
    pat = 128'h1;
    send(pat, 1'b0, c0);
    send('0, 1'b1, c0);
    pat = 128'h7;
    send(pat, 1'b1, c0);
    drain();

`ifdef POPCNT_ACC_EN
    // case 6: 8-bit accumulator saturates, then clears after last
    for (int i = 0; i < 4; i++) begin
      v6 = 1'b1;
      data_i = '1;
      last_i = 1'(i == 2);
      @(posedge clk);
      #1;
    end
    v6 = 1'b0;
    last_i = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("acc8_beats", idx6, 4);
`endif

    // random stream under random backpressure
    rnd_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      case ($urandom_range(0, 4))
        0:       pat = '1;
        1:       pat = '0;
        2:       pat = {$urandom, $urandom, $urandom, $urandom} & {$urandom, $urandom, $urandom, $urandom};
        default: pat = {$urandom, $urandom, $urandom, $urandom};
      endcase
      send(pat, 1'($urandom_range(0, 3) == 0), c0);
    end
    rnd_rdy = 1'b0;
    @(posedge clk);
    #2 ready_i = 1'b1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
